// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory responder with fixed latency, preload port, transfer counters and protocol-error flag
module mem_responder #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 inputReady,
  output logic                 busy,
  output logic                 err_both,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [WORD_SIZE-1:0] load_data,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, nextState;
  logic [WORD_SIZE-1:0] mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] addrQ, idx, respAddr, memWa;
  logic [WORD_SIZE-1:0] wdataQ, rdataQ, memWd;
  logic [3:0] cnt;
  logic opWrite, req, changed, respWrite, commit, memWe;
  logic unusedBits;
  assign unusedBits = ^address[WORD_SIZE-1:ADDR_BITS];
  always_comb begin
    idx = address[ADDR_BITS-1:0];
    req = readM ^ writeM;
    changed = (opWrite ? (!writeM || readM) : (!readM || writeM)) || idx != addrQ;
    nextState = state == IDLE ? (req ? (LATENCY == 1 ? RESP : BUSY) : IDLE)
              : state == BUSY ? (changed ? IDLE : cnt == 4'd0 ? RESP : BUSY)
              : IDLE;
    // with LATENCY==1 the access commits on the accept edge, before the request is latched
    respWrite = state == IDLE ? writeM : opWrite;
    respAddr = state == IDLE ? idx : addrQ;
    commit = nextState == RESP;
    memWe = commit ? respWrite : state == IDLE && !req && load_en;
    memWa = commit ? respAddr : load_addr;
    memWd = commit ? (state == IDLE ? data : wdataQ) : load_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      err_both <= 1'b0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && readM && writeM) err_both <= 1'b1;
      if (state == RESP) begin
        rd_count <= rd_count + 16'(!opWrite);
        wr_count <= wr_count + 16'(opWrite);
      end
      if (state == IDLE && req) begin
        opWrite <= writeM;
        addrQ <= idx;
        wdataQ <= data;
        cnt <= 4'(LATENCY - 2);
      end else if (state == BUSY) cnt <= cnt - 4'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && memWe) mem[memWa] <= memWd;
    if (!reset && commit && !respWrite) rdataQ <= mem[respAddr];
  end
  assign inputReady = state == RESP;
  assign busy = state != IDLE;
  assign data = (state == RESP && !opWrite && readM) ? rdataQ : 'z;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: checks three responders (latency 2, 3, 1) against a transaction-level model
module tb_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] rs, rd, wr, ld, dDrv, ir, bs, eb;
  logic [2:0][15:0] ad, dOut, lData, rc, wc;
  logic [2:0][7:0] la;
  wire [15:0] bus0, bus1, bus2;
  wire [2:0][15:0] busv = {bus2, bus1, bus0};
  assign bus0 = dDrv[0] ? dOut[0] : 'z;
  assign bus1 = dDrv[1] ? dOut[1] : 'z;
  assign bus2 = dDrv[2] ? dOut[2] : 'z;
  mem_responder #(.LATENCY(2)) u0 (.clk(clk), .reset(rs[0]), .readM(rd[0]), .writeM(wr[0]), .address(ad[0]), .data(bus0),
    .inputReady(ir[0]), .busy(bs[0]), .err_both(eb[0]), .load_en(ld[0]), .load_addr(la[0]), .load_data(lData[0]),
    .rd_count(rc[0]), .wr_count(wc[0]));
  mem_responder #(.LATENCY(3)) u1 (.clk(clk), .reset(rs[1]), .readM(rd[1]), .writeM(wr[1]), .address(ad[1]), .data(bus1),
    .inputReady(ir[1]), .busy(bs[1]), .err_both(eb[1]), .load_en(ld[1]), .load_addr(la[1]), .load_data(lData[1]),
    .rd_count(rc[1]), .wr_count(wc[1]));
  mem_responder #(.LATENCY(1)) u2 (.clk(clk), .reset(rs[2]), .readM(rd[2]), .writeM(wr[2]), .address(ad[2]), .data(bus2),
    .inputReady(ir[2]), .busy(bs[2]), .err_both(eb[2]), .load_en(ld[2]), .load_addr(la[2]), .load_data(lData[2]),
    .rd_count(rc[2]), .wr_count(wc[2]));
  int tests = 0, fails = 0;
  task automatic chk(string nm, int i, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[u%0d]: got %h expected %h at %0t", nm, i, act, exp, $time);
    end
  endtask
  // Model: a request is accepted, must be held unchanged for lat-1 further edges, then completes with a one-cycle pulse
  int lat[3] = '{2, 3, 1};
  bit mInF[3], mResp[3], mErr[3], mOpW[3], mRdV[3];
  int mK[3];
  logic [7:0] mA[3];
  logic [15:0] mWd[3], mRd[3], mRc[3], mWc[3];
  logic [15:0] mMem[3][256];
  bit mVal[3][256];
  function automatic void complete(int i);
    mInF[i] = 0;
    mResp[i] = 1;
    if (mOpW[i]) begin
      mMem[i][mA[i]] = mWd[i];
      mVal[i][mA[i]] = 1;
    end else begin
      mRd[i] = mMem[i][mA[i]];
      mRdV[i] = mVal[i][mA[i]];
    end
  endfunction
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rs[i]) begin
        mInF[i] = 0; mResp[i] = 0; mErr[i] = 0; mRc[i] = 0; mWc[i] = 0;
      end else if (mResp[i]) begin
        mResp[i] = 0;
        if (mOpW[i]) mWc[i] = mWc[i] + 1; else mRc[i] = mRc[i] + 1;
      end else if (mInF[i]) begin
        if (rd[i] != !mOpW[i] || wr[i] != mOpW[i] || ad[i][7:0] != mA[i]) mInF[i] = 0;
        else begin
          mK[i]++;
          if (mK[i] == lat[i] - 1) complete(i);
        end
      end else begin
        if (rd[i] && wr[i]) mErr[i] = 1;
        if (rd[i] ^ wr[i]) begin
          mOpW[i] = wr[i]; mA[i] = ad[i][7:0]; mWd[i] = dOut[i]; mK[i] = 0;
          if (lat[i] == 1) complete(i); else mInF[i] = 1;
        end else if (ld[i]) begin
          mMem[i][la[i]] = lData[i];
          mVal[i][la[i]] = 1;
        end
      end
    end
  end
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk("inputReady", i, 16'(ir[i]), 16'(mResp[i]));
      chk("busy", i, 16'(bs[i]), 16'(mInF[i] || mResp[i]));
      chk("err_both", i, 16'(eb[i]), 16'(mErr[i]));
      chk("rd_count", i, rc[i], mRc[i]);
      chk("wr_count", i, wc[i], mWc[i]);
      if (mResp[i] && !mOpW[i] && rd[i] && mRdV[i]) chk("data", i, busv[i], mRd[i]);
    end
  end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic preload(int i, logic [7:0] a, logic [15:0] d);
    ld[i] = 1; la[i] = a; lData[i] = d;
    step();
    ld[i] = 0;
  endtask
  task automatic access(int i, bit w, logic [15:0] a, logic [15:0] d, output int cyc, output logic [15:0] v);
    rd[i] = !w; wr[i] = w; ad[i] = a; dOut[i] = d; dDrv[i] = w;
    cyc = 0; v = '0;
    for (int k = 1; k <= 20 && cyc == 0; k++) begin
      step();
      if (ir[i]) begin cyc = k; v = busv[i]; end
    end
    rd[i] = 0; wr[i] = 0; dDrv[i] = 0;
    if (cyc == 0) begin
      tests++; fails++;
      $display("FAIL timeout[u%0d]: no inputReady within 20 cycles for address %h", i, a);
    end
    step();
  endtask
  int cyc, np;
  logic [15:0] v;
  logic [3:0] pat;
  initial begin
    rs = '1; rd = '0; wr = '0; ld = '0; dDrv = '0; ad = '0; dOut = '0; lData = '0; la = '0;
    step(); step();
    rs = '0;
    chk("rst_ready", 0, 16'(ir[0]), 16'd0);
    chk("rst_busy", 0, 16'(bs[0]), 16'd0);
    chk("rst_rc", 0, rc[0], 16'd0);
    preload(0, 8'h10, 16'hBEEF);
    access(0, 0, 16'h0010, 16'h0, cyc, v);
    chk("t1_latency", 0, 16'(cyc), 16'd2);
    chk("t1_data", 0, v, 16'hBEEF);
    chk("t1_rc", 0, rc[0], 16'd1);
    access(0, 1, 16'h0123, 16'h1234, cyc, v);
    chk("t2_wc", 0, wc[0], 16'd1);
    access(0, 0, 16'h0023, 16'h0, cyc, v);
    chk("t2_wrap_data", 0, v, 16'h1234);
    preload(0, 8'h06, 16'h0606);
    rd[0] = 1; ad[0] = 16'h0005;
    step();
    ad[0] = 16'h0006;
    step();
    chk("t3_no_pulse", 0, 16'(ir[0]), 16'd0);
    chk("t3_idle", 0, 16'(bs[0]), 16'd0);
    access(0, 0, 16'h0006, 16'h0, cyc, v);
    chk("t3_data", 0, v, 16'h0606);
    chk("t3_rc", 0, rc[0], 16'd3);
    rd[0] = 1; wr[0] = 1;
    step();
    rd[0] = 0; wr[0] = 0;
    chk("t4_err", 0, 16'(eb[0]), 16'd1);
    step(); step();
    chk("t4_err_sticky", 0, 16'(eb[0]), 16'd1);
    rs[0] = 1;
    step();
    rs[0] = 0;
    chk("t4_err_clr", 0, 16'(eb[0]), 16'd0);
    chk("t4_rc_clr", 0, rc[0], 16'd0);
    chk("t4_wc_clr", 0, wc[0], 16'd0);
    access(0, 0, 16'h0010, 16'h0, cyc, v);
    chk("t4_mem_kept", 0, v, 16'hBEEF);
    preload(1, 8'h02, 16'h5555);
    wr[1] = 1; ad[1] = 16'h0002; dOut[1] = 16'h00AA; dDrv[1] = 1; np = 0;
    step(); np += int'(ir[1]);
    step(); np += int'(ir[1]);
    rs[1] = 1;
    step(); np += int'(ir[1]);
    rs[1] = 0; wr[1] = 0; dDrv[1] = 0;
    step(); np += int'(ir[1]);
    chk("t5_no_pulse", 1, 16'(np), 16'd0);
    chk("t5_wc", 1, wc[1], 16'd0);
    access(1, 0, 16'h0002, 16'h0, cyc, v);
    chk("t5_latency", 1, 16'(cyc), 16'd3);
    chk("t5_mem_kept", 1, v, 16'h5555);
    preload(2, 8'h01, 16'h0101);
    rd[2] = 1; ad[2] = 16'h0001; pat = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      pat = {pat[2:0], ir[2]};
    end
    rd[2] = 0;
    chk("t6_pattern", 2, 16'(pat), 16'b1010);
    chk("t6_rc", 2, rc[2], 16'd2);
    step(); step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
